demux_1_4_reg: RTL and testbench
================================

DEMUX_1_4_REG -- requirements
Module: demux_1_4_reg

Interface
REQ-001 Parameter WIDTH, default 4, data width of the input word and of each output channel.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 d  input  WIDTH  input data word.
REQ-005 sel  input  2  destination channel index, 0..3.
REQ-006 in_valid  input  1  d and sel are valid this cycle.
REQ-007 in_ready  output  1  block accepts d this cycle; a transfer occurs when in_valid && in_ready.
REQ-008 y  output  4 x WIDTH (packed [3:0][WIDTH-1:0])  per-channel output data.
REQ-009 y_valid  output  4  per-channel output valid.
REQ-010 y_ready  input  4  per-channel downstream ready; a transfer on channel k occurs when y_valid[k] && y_ready[k].

Function
REQ-011 Each channel k SHALL own a one-entry holding slot: a data register plus a full flag that drives y_valid[k].
REQ-012 in_ready SHALL be combinational: in_ready = !full[sel] || y_ready[sel], and SHALL depend only on sel, full and y_ready, never on in_valid.
REQ-013 On an input transfer, d SHALL be written to slot[sel] and full[sel] set; y[sel] and y_valid[sel] show the word on the next cycle (latency 1).
REQ-014 On an output transfer on channel k with no simultaneous write to k, full[k] SHALL clear on the next edge.
REQ-015 Simultaneous output transfer on k and input transfer to k SHALL leave full[k] = 1 with the new word, so a continuously ready channel sustains one word per cycle.
REQ-016 Channels SHALL be independent: a stalled channel (y_ready[k] = 0, full[k] = 1) SHALL NOT block input transfers addressed to another channel.
REQ-017 While y_valid[k] = 1 and y_ready[k] = 0, y[k] SHALL hold stable.
REQ-018 Slot data of channels that are not full is don't-care for the bench; y[k] SHALL nevertheless reset to 0.
REQ-019 Words SHALL never be dropped or duplicated: each input transfer produces exactly one output transfer on channel sel, in per-channel arrival order.
REQ-020 When in_valid = 0, no slot is written, regardless of sel.

Reset
REQ-021 On rst_n low, all y_valid SHALL clear and all y SHALL become 0 immediately, without waiting for a clock edge.
REQ-022 During reset, in_ready SHALL still follow REQ-012, which evaluates to 1 because all slots are empty; input transfers during reset SHALL be discarded.
REQ-023 Reset asserted mid-operation SHALL discard all held words; the first edge after release SHALL behave as from the empty state.

Structure
REQ-024 Channel count 4 and the sel width 2 SHALL be localparams in a shared package, demux_pkg, together with a typedef for the channel index.
REQ-025 The per-channel holding logic SHALL be a sub-module, demux_slot, instantiated four times, with ports clk, rst_n, wr, wdata, rd (= y_ready), full and q.
REQ-026 The top level SHALL contain only the sel decode, the in_ready mux and the four demux_slot instances; target size is 120-250 RTL lines total.

Verification
REQ-027 After reset, y_valid[3:0] = 0 and in_ready = 1. Drive d = 4'hA, sel = 2, in_valid = 1 for 1 cycle -> next cycle y_valid = 4'b0100 and y[2] = 4'hA.
REQ-028 Hold y_ready[1] = 0 and send 4'h3 to sel 1. Then present sel = 1 again -> in_ready = 0 and y[1] stays 4'h3. Present sel = 0 -> in_ready = 1 and y[0] gets the new word.
REQ-029 With y_ready = 4'hF, stream 8 words 0..7 to sel 3 on consecutive cycles -> in_ready stays 1 and y[3] shows 0..7 on consecutive cycles, 1-cycle latency.
REQ-030 Fill all four slots with y_ready = 0 -> in_ready = 0 for every sel. Raise y_ready[2] while sending to sel 2 in the same cycle -> transfer accepted and full[2] stays 1 with the new word.
REQ-031 With slots 0 and 3 full, pulse rst_n low between clock edges -> y_valid = 0 and y = 0 immediately. After release, the slots accept new words normally.
REQ-032 Random scoreboard run of 10k cycles with random in_valid, sel, d and y_ready -> per-channel output sequence equals the input sequence filtered by sel, with no loss and no duplication.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 demultiplexer.
//   NUM_CH   : number of output channels
//   SEL_W    : width of the channel index
//   ch_idx_t : channel index type used for sel
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [SEL_W-1:0] ch_idx_t;

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One-entry holding slot for a single demux output channel.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, empties the slot and zeroes q
//   wr    : write strobe (an accepted input transfer addressed here)
//   wdata : word to store on wr
//   rd    : downstream ready; with full set it pops the held word
//   full  : slot holds a word (drives the channel's valid)
//   q     : held word
module demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic             full,
  output logic [WIDTH-1:0] q
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A write always wins: a pop and a write in the same cycle leave the slot
  // full with the new word, giving one word per cycle on a ready channel.
  always_comb begin
    full_d = wr | (full_q & ~rd);
    data_d = wr ? wdata : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign q    = data_q;

endmodule : demux_slot

// File: rtl/demux_1_4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes.
// Each channel owns a one-entry slot; the input word is steered to slot[sel].
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   d        : input word
//   sel      : destination channel index
//   in_valid : d/sel valid this cycle
//   in_ready : selected channel can take a word this cycle
//   y        : per-channel output words
//   y_valid  : per-channel output valid
//   y_ready  : per-channel downstream ready
module demux_1_4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH-1:0]              d,
  input  ch_idx_t                       sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_CH-1:0][WIDTH-1:0]  y,
  output logic [NUM_CH-1:0]             y_valid,
  input  logic [NUM_CH-1:0]             y_ready
);

  logic [NUM_CH-1:0] wr;

  // Ready looks only at the addressed slot, so a stalled channel never
  // blocks traffic to the others, and it never depends on in_valid.
  assign in_ready = !y_valid[sel] || y_ready[sel];

  always_comb begin
    wr = '0;
    if (in_valid && in_ready) begin
      wr[sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[k]),
      .wdata (d),
      .rd    (y_ready[k]),
      .full  (y_valid[k]),
      .q     (y[k])
    );
  end

endmodule : demux_1_4_reg

// File: tb/tb_demux_1_4_reg.sv
module tb_demux_1_4_reg;

  logic            clk;
  logic            rst_n;
  logic [3:0]      d;
  logic [1:0]      sel;
  logic            in_valid;
  logic            in_ready;
  logic [3:0][3:0] y;
  logic [3:0]      y_valid;
  logic [3:0]      y_ready;

  int n_vec;
  int n_err;

  // Scoreboard storage: per-channel arrival order.
  logic [3:0] sb_mem [4][0:16383];
  int         sb_wp  [4];
  int         sb_rp  [4];

  demux_1_4_reg #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    d        = 4'h5;
    sel      = 2'd0;
    in_valid = 1'b1;
    y_ready  = 4'h0;
    for (int k = 0; k < 4; k++) begin
      sb_wp[k] = 0;
      sb_rp[k] = 0;
    end

    // Reset state; a transfer offered during reset is discarded.
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    tick();
    chk("rst_discard_valid", 32'(y_valid), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("post_rst_valid", 32'(y_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // in_valid low writes nothing.
    d = 4'hF; sel = 2'd1;
    tick();
    chk("no_valid_no_write", 32'(y_valid), 32'd0);

    // Single word to channel 2, latency 1.
    d = 4'hA; sel = 2'd2; in_valid = 1'b1;
    #1;
    chk("c2_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("c2_y_valid", 32'(y_valid), 32'b0100);
    chk("c2_y", 32'(y[2]), 32'hA);
    y_ready = 4'b0100;
    tick();
    y_ready = 4'h0;
    chk("c2_drained", 32'(y_valid), 32'd0);

    // Stalled channel 1 blocks only itself.
    d = 4'h3; sel = 2'd1; in_valid = 1'b1;
    tick();
    chk("c1_valid", 32'(y_valid), 32'b0010);
    chk("c1_y", 32'(y[1]), 32'h3);
    d = 4'h9;
    #1;
    chk("c1_stall_ready", 32'(in_ready), 32'd0);
    tick();
    chk("c1_hold_y", 32'(y[1]), 32'h3);
    chk("c1_hold_valid", 32'(y_valid), 32'b0010);
    d = 4'h6; sel = 2'd0;
    #1;
    chk("c0_ready_while_c1_stalled", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("c0_y", 32'(y[0]), 32'h6);
    chk("c0c1_valid", 32'(y_valid), 32'b0011);
    chk("c1_still_3", 32'(y[1]), 32'h3);
    y_ready = 4'hF;
    tick();
    chk("c0c1_drained", 32'(y_valid), 32'd0);

    // Streaming 0..7 into channel 3 with downstream always ready.
    sel = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 4'(i);
      #1;
      chk("stream_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_y3", 32'(y[3]), 32'(i));
      chk("stream_v3", 32'(y_valid[3]), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(y_valid), 32'd0);

    // Fill all four slots with no downstream ready.
    y_ready  = 4'h0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      d   = 4'(k + 8);
      tick();
    end
    in_valid = 1'b0;
    chk("all_full", 32'(y_valid), 32'hF);
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      #1;
      chk("full_not_ready", 32'(in_ready), 32'd0);
    end
    // Simultaneous pop and push on channel 2.
    sel = 2'd2; d = 4'hC; y_ready = 4'b0100; in_valid = 1'b1;
    #1;
    chk("c2_pass_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    y_ready  = 4'h0;
    chk("c2_pass_full", 32'(y_valid), 32'hF);
    chk("c2_pass_y", 32'(y[2]), 32'hC);
    chk("c0_untouched", 32'(y[0]), 32'h8);

    // Keep only slots 0 and 3 full, then reset between edges.
    y_ready = 4'b0110;
    tick();
    y_ready = 4'h0;
    chk("slots_0_3", 32'(y_valid), 32'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(y_valid), 32'd0);
    chk("async_rst_y", 32'(y), 32'd0);
    rst_n = 1'b1;
    sel = 2'd3; d = 4'hE; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("after_rst_valid", 32'(y_valid), 32'b1000);
    chk("after_rst_y3", 32'(y[3]), 32'hE);
    y_ready = 4'hF;
    tick();
    chk("after_rst_drained", 32'(y_valid), 32'd0);

    // Random scoreboard run.
    for (int c = 0; c < 10000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      sel      = 2'($urandom_range(0, 3));
      d        = 4'($urandom_range(0, 15));
      y_ready  = 4'($urandom_range(0, 15));
      #1;
      chk("sb_in_ready", 32'(in_ready),
          32'((sb_wp[sel] == sb_rp[sel]) || y_ready[sel]));
      for (int k = 0; k < 4; k++) begin
        chk("sb_y_valid", 32'(y_valid[k]), 32'(sb_wp[k] != sb_rp[k]));
        if (y_valid[k] && y_ready[k]) begin
          if (sb_rp[k] < sb_wp[k]) begin
            chk("sb_data", 32'(y[k]), 32'(sb_mem[k][sb_rp[k]]));
            sb_rp[k]++;
          end else begin
            chk("sb_unexpected_pop", 32'd1, 32'd0);
          end
        end
      end
      if (in_valid && in_ready && sb_wp[sel] < 16384) begin
        sb_mem[sel][sb_wp[sel]] = d;
        sb_wp[sel]++;
      end
      tick();
    end
    in_valid = 1'b0;
    y_ready  = 4'hF;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (y_valid[k]) begin
        if (sb_rp[k] < sb_wp[k]) begin
          chk("sb_final_data", 32'(y[k]), 32'(sb_mem[k][sb_rp[k]]));
          sb_rp[k]++;
        end else begin
          chk("sb_final_extra", 32'd1, 32'd0);
        end
      end
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("sb_all_delivered", 32'(sb_wp[k] - sb_rp[k]), 32'd0);
    end
    chk("sb_end_empty", 32'(y_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_demux_1_4_reg
